csr_trap_unit: RTL and testbench

- Parametrised machine-mode CSR file with a registered trap/return sequencer for the pipelined RISC-V core; successor to the current CSR block.
- Supports CSRRW/CSRRS/CSRRC writes, mstatus MIE/MPIE stacking, mcause/mepc capture, direct or vectored mtvec, NUM_IRQ synchronised interrupt lines with fixed priority, and optional 64-bit cycle/instret counters.
- Sits beside the commit stage; drives a one-cycle redirect and flush to the fetch unit.

---
 rtl/csr_pkg.sv | 25 ++
 rtl/csr_irq_sync.sv | 39 +++
 rtl/csr_trap_unit.sv | 120 ++++++++++++
 tb/tb_csr_trap_unit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, operation/state enums and interrupt cause encodings for csr_trap_unit
package csr_pkg;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam logic [4:0] CAUSE_MTI   = 5'd7;
  localparam logic [4:0] CAUSE_MEI   = 5'd11;
  localparam logic [4:0] CAUSE_LOCAL = 5'd16;
  typedef enum logic [1:0] {CSR_NONE, CSR_WRITE, CSR_SET, CSR_CLEAR} csr_op_e;
  typedef enum logic {RUN, REDIRECT} state_e;
  // mip bit (and cause code) for interrupt line k
  function automatic logic [4:0] irq_bit(input int k);
    return k == 0 ? CAUSE_MTI : k == 1 ? CAUSE_MEI : CAUSE_LOCAL + 5'(k - 2);
  endfunction
endpackage

// File: rtl/csr_irq_sync.sv
// csr_irq_sync: 2-flop synchronisers for the irq lines, mip mapping and fixed-priority cause encoder
module csr_irq_sync
  import csr_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_IRQ = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [XLEN-1:0]    mie_i,
  output logic [XLEN-1:0]    mip_o,
  output logic               irq_valid_o,
  output logic [4:0]         cause_o
);
  logic [NUM_IRQ-1:0] meta_q, sync_q;
  logic [XLEN-1:0] pend;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= irq_i;
      sync_q <= meta_q;
    end
  always_comb begin
    mip_o = '0;
    for (int k = 0; k < NUM_IRQ; k++) mip_o[irq_bit(k)] = sync_q[k];
  end
  assign pend        = mip_o & mie_i;
  assign irq_valid_o = |pend;
  // later assignments win: locals scanned high-to-low, then MTI, then MEI on top
  always_comb begin
    cause_o = '0;
    for (int k = NUM_IRQ - 1; k >= 2; k--) if (pend[irq_bit(k)]) cause_o = irq_bit(k);
    if (pend[CAUSE_MTI]) cause_o = CAUSE_MTI;
    if (pend[CAUSE_MEI]) cause_o = CAUSE_MEI;
  end
endmodule

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file with registered trap/MRET redirect sequencer.
// Define CSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              NUM_IRQ   = 2,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               csr_illegal,
  input  logic [XLEN-1:0]    pc_i,
  input  logic               instr_retire,
  input  logic               is_mret,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               trap_taken,
  output logic [XLEN-1:0]    trap_pc
);
  state_e state_q, state_d;
  logic st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, trap_pc_q, trap_pc_d;
  logic [XLEN-1:0] mip, rd, wval, vec_pc;
  logic [4:0] cause;
  logic irq_valid, irq_take, mret_take, hit, wr;
  csr_irq_sync #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) u_sync (
    .clk(clk), .reset(reset), .irq_i(irq_i), .mie_i(mie_q),
    .mip_o(mip), .irq_valid_o(irq_valid), .cause_o(cause)
  );
`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d, cyc_inc, ret_inc;
`else
  logic unused_retire;
  assign unused_retire = instr_retire;
`endif
  always_comb begin
    rd  = '0;
    hit = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:   rd = XLEN'({st_mpie_q, 3'b000, st_mie_q, 3'b000});
      CSR_MIE:       rd = mie_q;
      CSR_MTVEC:     rd = mtvec_q;
      CSR_MSCRATCH:  rd = mscratch_q;
      CSR_MEPC:      rd = mepc_q;
      CSR_MCAUSE:    rd = mcause_q;
      CSR_MIP:       rd = mip;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    rd = XLEN'(mcycle_q[31:0]);
      CSR_MCYCLEH:   rd = XLEN'(mcycle_q[63:32]);
      CSR_MINSTRET:  rd = XLEN'(minstret_q[31:0]);
      CSR_MINSTRETH: rd = XLEN'(minstret_q[63:32]);
`endif
      default:       hit = 1'b0;
    endcase
  end
  assign csr_illegal = csr_op != CSR_NONE && !hit;
  assign csr_rdata   = csr_op == CSR_NONE ? '0 : rd;
  assign irq_take    = irq_valid && st_mie_q && state_q == RUN;
  assign mret_take   = is_mret && state_q == RUN && !irq_take;
  // a taken interrupt suppresses the commit-stage instruction's CSR write
  assign wr     = csr_op != CSR_NONE && hit && !irq_take;
  assign wval   = csr_op == CSR_WRITE ? csr_wdata : csr_op == CSR_SET ? rd | csr_wdata : rd & ~csr_wdata;
  assign vec_pc = (mtvec_q & ~XLEN'(3)) + (mtvec_q[1:0] == 2'b01 ? XLEN'(cause) << 2 : '0);
  always_comb begin
    state_d    = irq_take || mret_take ? REDIRECT : RUN;
    trap_pc_d  = irq_take ? vec_pc : mret_take ? mepc_q : trap_pc_q;
    st_mie_d   = irq_take ? 1'b0 : mret_take ? st_mpie_q : wr && csr_addr == CSR_MSTATUS ? wval[MSTATUS_MIE] : st_mie_q;
    st_mpie_d  = irq_take ? st_mie_q : mret_take ? 1'b1 : wr && csr_addr == CSR_MSTATUS ? wval[MSTATUS_MPIE] : st_mpie_q;
    mie_d      = wr && csr_addr == CSR_MIE ? wval : mie_q;
    mtvec_d    = wr && csr_addr == CSR_MTVEC ? wval : mtvec_q;
    mscratch_d = wr && csr_addr == CSR_MSCRATCH ? wval : mscratch_q;
    mepc_d     = irq_take ? pc_i & ~XLEN'(3) : wr && csr_addr == CSR_MEPC ? wval & ~XLEN'(3) : mepc_q;
    mcause_d   = irq_take ? {1'b1, (XLEN-1)'(cause)} : wr && csr_addr == CSR_MCAUSE ? wval : mcause_q;
  end
`ifdef CSR_COUNTERS_EN
  assign cyc_inc = mcycle_q + 64'd1;
  assign ret_inc = minstret_q + 64'(instr_retire && !irq_take);
  assign mcycle_d   = {wr && csr_addr == CSR_MCYCLEH ? wval[31:0] : cyc_inc[63:32],
                       wr && csr_addr == CSR_MCYCLE ? wval[31:0] : cyc_inc[31:0]};
  assign minstret_d = {wr && csr_addr == CSR_MINSTRETH ? wval[31:0] : ret_inc[63:32],
                       wr && csr_addr == CSR_MINSTRET ? wval[31:0] : ret_inc[31:0]};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q    <= RUN;
      trap_pc_q  <= '0;
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= RESET_VEC;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      state_q    <= state_d;
      trap_pc_q  <= trap_pc_d;
      st_mie_q   <= st_mie_d;
      st_mpie_q  <= st_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  assign trap_taken = state_q == REDIRECT;
  assign trap_pc    = trap_pc_q;
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: table-driven CSR access vectors plus hand-written trap/MRET/reset sequences
module tb_csr_trap_unit;
  localparam logic [31:0] RV = 32'h0000_0200;
  logic        clk = 1'b0, reset = 1'b0;
  logic [1:0]  csr_op = '0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0, pc_i = '0, csr_rdata, trap_pc;
  logic        csr_illegal, instr_retire = 1'b0, is_mret = 1'b0, trap_taken;
  logic [1:0]  irq_i = '0;
  int checks = 0, errors = 0;
  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ill;
  } vec_t;
  vec_t vq[$];
  csr_trap_unit #(.XLEN(32), .NUM_IRQ(2), .RESET_VEC(RV)) dut (
    .clk(clk), .reset(reset), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .pc_i(pc_i), .instr_retire(instr_retire),
    .is_mret(is_mret), .irq_i(irq_i), .trap_taken(trap_taken), .trap_pc(trap_pc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_op = op; csr_addr = a; csr_wdata = d;
    tick();
    csr_op = 2'b00;
  endtask
  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_op = 2'b10; csr_addr = a; csr_wdata = '0;
    #1;
    chk(name, csr_rdata, exp);
    tick();
    csr_op = 2'b00;
  endtask
  function automatic void add(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input logic ill);
    vq.push_back('{op, a, wd, rd, ill});
  endfunction
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
  initial begin
    add(2'b10, 12'h300, 0, 0, 0);
    add(2'b10, 12'h304, 0, 0, 0);
    add(2'b10, 12'h305, 0, RV, 0);
    add(2'b10, 12'h340, 0, 0, 0);
    add(2'b10, 12'h341, 0, 0, 0);
    add(2'b10, 12'h342, 0, 0, 0);
    add(2'b10, 12'h344, 0, 0, 0);
    add(2'b10, 12'h7C0, 0, 0, 1);
    add(2'b00, 12'h305, 0, 0, 0);
    add(2'b01, 12'h340, 32'hF0, 0, 0);
    add(2'b10, 12'h340, 32'h0F, 32'hF0, 0);
    add(2'b11, 12'h340, 32'hF0, 32'hFF, 0);
    add(2'b10, 12'h340, 0, 32'h0F, 0);
    add(2'b01, 12'h341, 32'h43, 0, 0);
    add(2'b01, 12'h341, 0, 32'h40, 0);
    add(2'b01, 12'h344, 32'hFFFF, 0, 0);
    add(2'b10, 12'h344, 0, 0, 0);
    add(2'b01, 12'h300, 32'hFFFF_FFFF, 0, 0);
    add(2'b01, 12'h300, 0, 32'h88, 0);
    add(2'b10, 12'h300, 0, 0, 0);
    add(2'b01, 12'h304, 32'h880, 0, 0);
    add(2'b01, 12'h305, 32'h100, RV, 0);
    add(2'b10, 12'h300, 32'h8, 0, 0);
    #12;
    chk("reset trap_taken", trap_taken, 0);
    chk("reset trap_pc", trap_pc, 0);
    @(negedge clk) reset = 1'b1;
    tick();
    foreach (vq[i]) begin
      csr_op = vq[i].op; csr_addr = vq[i].addr; csr_wdata = vq[i].wd;
      #1;
      chk($sformatf("vec%0d rdata", i), csr_rdata, vq[i].rd);
      chk($sformatf("vec%0d illegal", i), csr_illegal, vq[i].ill);
      chk($sformatf("vec%0d trap_taken", i), trap_taken, 0);
      tick();
    end
    csr_op = 2'b00;
    // direct-mode MTI trap: two synchroniser stages, then a registered redirect
    pc_i = 32'h40; irq_i = 2'b01;
    tick(); chk("mti lat1", trap_taken, 0);
    tick(); chk("mti lat2", trap_taken, 0);
    tick(); chk("mti taken", trap_taken, 1); chk("mti trap_pc", trap_pc, 32'h100);
    irq_i = 2'b00;
    tick(); chk("mti one cycle", trap_taken, 0);
    rd_chk("mti mepc", 12'h341, 32'h40);
    rd_chk("mti mcause", 12'h342, 32'h8000_0007);
    rd_chk("mti mstatus", 12'h300, 32'h80);
    rd_chk("mip cleared", 12'h344, 0);
    // MRET back to mepc
    pc_i = 32'h99; is_mret = 1'b1;
    tick(); chk("mret taken", trap_taken, 1); chk("mret trap_pc", trap_pc, 32'h40);
    is_mret = 1'b0;
    tick(); chk("mret one cycle", trap_taken, 0);
    rd_chk("mret mstatus", 12'h300, 32'h88);
    // vectored MEI+MTI with simultaneous MRET and mscratch write
    wr(2'b01, 12'h305, 32'h101);
    irq_i = 2'b11;
    tick(); tick();
    csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h55; is_mret = 1'b1; pc_i = 32'h80;
    #1 chk("mscratch old", csr_rdata, 32'h0F);
    tick(); chk("mei taken", trap_taken, 1); chk("mei trap_pc", trap_pc, 32'h12C);
    csr_op = 2'b00; irq_i = 2'b00;
    tick(); chk("mret ignored in redirect", trap_taken, 0);
    is_mret = 1'b0;
    rd_chk("mei mepc", 12'h341, 32'h80);
    rd_chk("mei mcause", 12'h342, 32'h8000_000B);
    rd_chk("suppressed write", 12'h340, 32'h0F);
    rd_chk("mei mstatus", 12'h300, 32'h80);
`ifdef CSR_COUNTERS_EN
    wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    tick();
    rd_chk("mcycleh carry", 12'hB80, 32'h1);
`else
    csr_op = 2'b10; csr_addr = 12'hB00;
    #1 chk("mcycle illegal", csr_illegal, 1); chk("mcycle rdata", csr_rdata, 0);
    csr_addr = 12'hB82;
    #1 chk("minstreth illegal", csr_illegal, 1);
    tick();
    csr_op = 2'b00;
`endif
    // async reset during REDIRECT
    is_mret = 1'b1;
    tick(); chk("pre-reset taken", trap_taken, 1); chk("pre-reset trap_pc", trap_pc, 32'h80);
    is_mret = 1'b0;
    #2 reset = 1'b0;
    #1 chk("async drop", trap_taken, 0); chk("async trap_pc", trap_pc, 0);
    @(negedge clk) reset = 1'b1;
    tick();
    rd_chk("post-reset mtvec", 12'h305, RV);
    rd_chk("post-reset mepc", 12'h341, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
